// File: rtl/fifo_rd_stream.sv
// Request-mode async-FIFO read side feeding a valid/ready stream through a
// 2-entry skid buffer, with frame (m_last) framing and a completed-frame counter.
module fifo_rd_stream #(
  parameter int DW      = 16,
  parameter int PKT_LEN = 4,
  parameter int U_DLY   = 1
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_rd_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [15:0]   frame_cnt,
  output logic [1:0]    buf_cnt
);

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  if (DW < 1 || DW > 1024 || PKT_LEN < 1 || PKT_LEN > 65535 || U_DLY < 0) begin : g_bad_param
    $error("fifo_rd_stream: parameter out of range");
  end

  logic          inflight;
  logic [DW-1:0] head;
  logic [DW-1:0] tail;
  logic [15:0]   beat;
  logic          push;
  logic          pop;
  logic [2:0]    occ_next;

  assign m_valid  = (buf_cnt != 2'd0);
  assign m_last   = m_valid & (beat == LAST_BEAT);
  assign m_data   = head;
  assign pop      = m_valid & m_ready;
  assign push     = inflight;

  // Occupancy the buffer will have once this cycle's pop and the pending return settle.
  assign occ_next   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = ~fifo_empty & ~rst & (occ_next < 3'd2);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      buf_cnt <= '0;
      head    <= '0;
      tail    <= '0;
    end else begin
      buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
      case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) head <= fifo_rd_data;
          else                 tail <= fifo_rd_data;
        end
        2'b01: head <= tail;
        2'b11: begin
          // With one entry the incoming word bypasses straight to the head.
          if (buf_cnt == 2'd1) begin
            head <= fifo_rd_data;
          end else begin
            head <= tail;
            tail <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      beat      <= '0;
      frame_cnt <= '0;
    end else begin
      if (pop) beat <= (beat == LAST_BEAT) ? '0 : beat + 16'd1;
      if (pop & m_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  a_occupancy: assert property (@(posedge clk_sys) disable iff (rst)
    ({1'b0, buf_cnt} + {2'b00, inflight}) <= 3'd2);
  a_no_overflow: assert property (@(posedge clk_sys) disable iff (rst)
    !(push && !pop && buf_cnt == 2'd2));

endmodule
